// File: rtl/hms_pkg.sv
// -----------------------------------------------------------------------------
// hms_pkg
// Shared definitions for the merge-input feeder slice: FSM state encoding,
// merge port select encoding, default geometry and helpers for the records-
// per-word count, word width and the max-key sentinel record.
// No ports (package).
// -----------------------------------------------------------------------------
package hms_pkg;

   localparam int unsigned E_LOG_DEF = 2;
   localparam int unsigned DATW_DEF  = 64;
   localparam int unsigned KEYW_DEF  = 32;

   // Upper bound for the sentinel helper; callers truncate to their DATW.
   localparam int unsigned MAX_DATW  = 1024;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      SEND = 2'd1,
      TERM = 2'd2
   } state_t;

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_t;

   function automatic int unsigned rec_per_word(input int unsigned e_log);
      return 32'd1 << e_log;
   endfunction

   function automatic int unsigned word_width(input int unsigned datw,
                                              input int unsigned e_log);
      return datw << e_log;
   endfunction

   // Key field all ones, payload above the key zero.
   function automatic logic [MAX_DATW-1:0] sentinel_rec(input int unsigned datw,
                                                        input int unsigned keyw);
      logic [MAX_DATW-1:0] r;
      r = '0;
      for (int unsigned b = 0; b < MAX_DATW; b++) begin
         if (b < keyw && b < datw) r[b] = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/hms_word_packer.sv
// -----------------------------------------------------------------------------
// hms_word_packer
// Collects single records into an E-record word (E = 1<<E_LOG). Records fill
// lanes 0..E-1 in arrival order; when the lane E-1 is written or the record
// is flagged last, the remaining upper lanes are padded with sentinels and
// the lane index returns to 0.
// Ports:
//   clk, rst   clock, synchronous active-high reset (clears lane index)
//   wr         record accepted this cycle
//   data       record to write into the current lane
//   last       record is the last of its run
//   done       this write completes a word (combinational)
//   busy       a partial word is held (lane index non-zero)
//   word       packed word, lane i at bits [DATW*(i+1)-1 : DATW*i]
// -----------------------------------------------------------------------------
module hms_word_packer
   import hms_pkg::*;
#(
   parameter int unsigned E_LOG = E_LOG_DEF,
   parameter int unsigned DATW  = DATW_DEF,
   parameter int unsigned KEYW  = KEYW_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr,
   input  logic [DATW-1:0]           data,
   input  logic                      last,
   output logic                      done,
   output logic                      busy,
   output logic [(DATW<<E_LOG)-1:0]  word
);

   localparam int unsigned   E    = rec_per_word(E_LOG);
   localparam logic [DATW-1:0] SENT = DATW'(sentinel_rec(DATW, KEYW));

   logic [E_LOG-1:0] idx;
   logic [DATW-1:0]  lane [E];

   assign done = wr && ((idx == E_LOG'(E - 1)) || last);
   assign busy = (idx != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         idx <= '0;
      end else if (wr) begin
         idx <= done ? '0 : idx + 1'b1;
      end
   end

   // Lane storage needs no reset; the padding on completion makes every
   // emitted lane defined.
   always_ff @(posedge clk) begin
      if (wr) begin
         for (int unsigned i = 0; i < E; i++) begin
            if (E_LOG'(i) == idx) begin
               lane[i] <= data;
            end else if (done && (E_LOG'(i) > idx)) begin
               lane[i] <= SENT;
            end
         end
      end
   end

   always_comb begin
      word = '0;
      for (int unsigned i = 0; i < E; i++) begin
         word[DATW*i +: DATW] = lane[i];
      end
   end

endmodule

// File: rtl/hms_run_feeder.sv
// -----------------------------------------------------------------------------
// hms_run_feeder
// Upstream transmitter for the two-input merge logic. Packs each sorted run of
// records into E-record words, pads the final word of a run with max-key
// sentinels and enqueues the words into merge input A or B under FUL
// backpressure. Runs alternate A, B, A, ...
// Build option: define HMS_FEEDER_TERM_WORD_EN to follow every run with an
// extra all-sentinel word (TERM state); RUN_DONE then marks that word.
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   IN_DATA/VALID/LAST  record stream, LAST marks the end of a run
//   IN_READY            record accepted this cycle when IN_VALID is high
//   FUL_A, FUL_B        merge FIFO full flags
//   ENQ_A, ENQ_B        enqueue strobes (never both high)
//   DOT_A, DOT_B        word presented to each port
//   RUN_DONE            pulse with the last word of a run
//   BUSY                partial word held or word pending
// -----------------------------------------------------------------------------
module hms_run_feeder
   import hms_pkg::*;
#(
   parameter int unsigned E_LOG = E_LOG_DEF,
   parameter int unsigned DATW  = DATW_DEF,
   parameter int unsigned KEYW  = KEYW_DEF
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [DATW-1:0]           IN_DATA,
   input  logic                      IN_VALID,
   input  logic                      IN_LAST,
   output logic                      IN_READY,
   input  logic                      FUL_A,
   input  logic                      FUL_B,
   output logic                      ENQ_A,
   output logic                      ENQ_B,
   output logic [(DATW<<E_LOG)-1:0]  DOT_A,
   output logic [(DATW<<E_LOG)-1:0]  DOT_B,
   output logic                      RUN_DONE,
   output logic                      BUSY
);

   localparam int unsigned     E    = rec_per_word(E_LOG);
   localparam int unsigned     WW   = word_width(DATW, E_LOG);
   localparam logic [DATW-1:0] SENT = DATW'(sentinel_rec(DATW, KEYW));

   state_t          state, state_nx;
   port_t           sel, sel_nx;
   logic            last_flag, last_nx;
   logic            accept;
   logic            pk_done, pk_busy;
   logic [WW-1:0]   pk_word;
   logic [WW-1:0]   term_word;
   logic            ful_sel;
   logic            enq;

   assign term_word = {E{SENT}};
   assign ful_sel   = (sel == PORT_A) ? FUL_A : FUL_B;
   assign accept    = IN_VALID && IN_READY;

   hms_word_packer #(
      .E_LOG (E_LOG),
      .DATW  (DATW),
      .KEYW  (KEYW)
   ) u_packer (
      .clk   (CLK),
      .rst   (RST),
      .wr    (accept),
      .data  (IN_DATA),
      .last  (IN_LAST),
      .done  (pk_done),
      .busy  (pk_busy),
      .word  (pk_word)
   );

   // State register
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= FILL;
         sel       <= PORT_A;
         last_flag <= 1'b0;
      end else begin
         state     <= state_nx;
         sel       <= sel_nx;
         last_flag <= last_nx;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      sel_nx   = sel;
      last_nx  = last_flag;
      case (state)
         FILL: begin
            if (pk_done) begin
               state_nx = SEND;
               last_nx  = IN_LAST;
            end
         end
         SEND: begin
            if (!ful_sel) begin
               if (last_flag) begin
`ifdef HMS_FEEDER_TERM_WORD_EN
                  state_nx = TERM;
`else
                  state_nx = FILL;
                  sel_nx   = port_t'(~sel);
`endif
               end else begin
                  state_nx = FILL;
               end
            end
         end
`ifdef HMS_FEEDER_TERM_WORD_EN
         TERM: begin
            if (!ful_sel) begin
               state_nx = FILL;
               sel_nx   = port_t'(~sel);
            end
         end
`endif
         default: state_nx = FILL;
      endcase
   end

   // Outputs; held low while RST is asserted.
   always_comb begin
      IN_READY = (state == FILL) && !RST;
      enq      = (state != FILL) && !ful_sel && !RST;
      ENQ_A    = enq && (sel == PORT_A);
      ENQ_B    = enq && (sel == PORT_B);
`ifdef HMS_FEEDER_TERM_WORD_EN
      RUN_DONE = enq && (state == TERM);
`else
      RUN_DONE = enq && last_flag;
`endif
      DOT_A    = (state == TERM) ? term_word : pk_word;
      DOT_B    = DOT_A;
      BUSY     = (pk_busy || (state != FILL)) && !RST;
   end

endmodule

// File: tb/tb_hms_run_feeder.sv
// -----------------------------------------------------------------------------
// tb_hms_run_feeder
// Scoreboard bench for hms_run_feeder (E_LOG=2, DATW=64, KEYW=32). Expected
// words are computed when records are driven and pushed per port; a monitor
// pops and compares on every ENQ. Honours HMS_FEEDER_TERM_WORD_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hms_run_feeder;

   localparam logic [63:0] SENT = 64'h0000_0000_FFFF_FFFF;

   typedef struct packed {
      logic [255:0] w;
      logic         done;
   } exp_t;

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic [63:0]  IN_DATA = '0;
   logic         IN_VALID = 1'b0;
   logic         IN_LAST = 1'b0;
   logic         IN_READY;
   logic         FUL_A = 1'b0;
   logic         FUL_B = 1'b0;
   logic         ENQ_A, ENQ_B;
   logic [255:0] DOT_A, DOT_B;
   logic         RUN_DONE;
   logic         BUSY;

   int unsigned  n_tests = 0;
   int unsigned  n_fail  = 0;

   exp_t         qa[$];
   exp_t         qb[$];
   logic [63:0]  m_lane [4];
   int unsigned  m_idx  = 0;
   logic         m_port = 1'b0;
   exp_t         mon_e;

   // 0: fixed ful_a_set/ful_b_set, 1: random, 2: FUL_A toggles, FUL_B fixed
   int unsigned  ful_mode  = 0;
   logic         ful_a_set = 1'b0;
   logic         ful_b_set = 1'b0;

   always #5 CLK = ~CLK;

   hms_run_feeder #(
      .E_LOG (2),
      .DATW  (64),
      .KEYW  (32)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .IN_DATA  (IN_DATA),
      .IN_VALID (IN_VALID),
      .IN_LAST  (IN_LAST),
      .IN_READY (IN_READY),
      .FUL_A    (FUL_A),
      .FUL_B    (FUL_B),
      .ENQ_A    (ENQ_A),
      .ENQ_B    (ENQ_B),
      .DOT_A    (DOT_A),
      .DOT_B    (DOT_B),
      .RUN_DONE (RUN_DONE),
      .BUSY     (BUSY)
   );

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // FUL flags change shortly after the rising edge, away from sampling.
   always @(posedge CLK) begin
      #2;
      case (ful_mode)
         1: begin
            FUL_A = ($urandom_range(0, 3) == 0);
            FUL_B = ($urandom_range(0, 3) == 0);
         end
         2: begin
            FUL_A = ~FUL_A;
            FUL_B = ful_b_set;
         end
         default: begin
            FUL_A = ful_a_set;
            FUL_B = ful_b_set;
         end
      endcase
   end

   always @(negedge CLK) begin
      if (!RST) begin
         if (ENQ_A && ENQ_B) chk("enq_both", 1, 0);
         if (ENQ_A) begin
            chk("ful_a_enq", FUL_A, 0);
            chk("ready_in_send_a", IN_READY, 0);
            if (qa.size() == 0) chk("unexpected_enq_a", 1, 0);
            else begin
               mon_e = qa.pop_front();
               chk("word_a", DOT_A, mon_e.w);
               chk("run_done_a", RUN_DONE, mon_e.done);
            end
         end
         if (ENQ_B) begin
            chk("ful_b_enq", FUL_B, 0);
            chk("ready_in_send_b", IN_READY, 0);
            if (qb.size() == 0) chk("unexpected_enq_b", 1, 0);
            else begin
               mon_e = qb.pop_front();
               chk("word_b", DOT_B, mon_e.w);
               chk("run_done_b", RUN_DONE, mon_e.done);
            end
         end
         if (RUN_DONE && !ENQ_A && !ENQ_B) chk("run_done_idle", 1, 0);
      end
   end

   task automatic push_exp(input exp_t e);
      if (m_port == 1'b0) qa.push_back(e);
      else                qb.push_back(e);
   endtask

   task automatic model_rec(input logic [63:0] d, input logic last);
      exp_t e;
      m_lane[m_idx] = d;
      if (m_idx == 3 || last) begin
         for (int unsigned i = m_idx + 1; i < 4; i++) m_lane[i] = SENT;
         e.w    = {m_lane[3], m_lane[2], m_lane[1], m_lane[0]};
         e.done = last;
`ifdef HMS_FEEDER_TERM_WORD_EN
         e.done = 1'b0;
         push_exp(e);
         if (last) begin
            e.w    = {SENT, SENT, SENT, SENT};
            e.done = 1'b1;
            push_exp(e);
         end
`else
         push_exp(e);
`endif
         if (last) m_port = ~m_port;
         m_idx = 0;
      end else begin
         m_idx++;
      end
   endtask

   task automatic send_rec(input logic [63:0] d, input logic last);
      int unsigned waitc;
      waitc = 0;
      @(negedge CLK);
      IN_DATA  = d;
      IN_LAST  = last;
      IN_VALID = 1'b1;
      while (!IN_READY && waitc < 1000) begin
         @(negedge CLK);
         waitc++;
      end
      if (!IN_READY) chk("accept_timeout", 1, 0);
      else model_rec(d, last);
      @(posedge CLK);
      #1;
      IN_VALID = 1'b0;
      IN_LAST  = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST      = 1'b1;
      IN_VALID = 1'b0;
      @(negedge CLK);
      chk("rst_enq_a", ENQ_A, 0);
      chk("rst_enq_b", ENQ_B, 0);
      chk("rst_run_done", RUN_DONE, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_in_ready", IN_READY, 0);
      qa.delete();
      qb.delete();
      m_idx  = 0;
      m_port = 1'b0;
      RST    = 1'b0;
      @(negedge CLK);
      chk("post_rst_in_ready", IN_READY, 1);
      chk("post_rst_busy", BUSY, 0);
   endtask

   task automatic drain(input string tag);
      int unsigned c;
      c = 0;
      while ((qa.size() + qb.size()) != 0 && c < 200) begin
         @(negedge CLK);
         c++;
      end
      chk(tag, 256'(qa.size() + qb.size()), 0);
   endtask

   initial begin : main
      logic [255:0] held;
      int unsigned  nrec;
      int unsigned  rlen;

      do_reset();

      // Full word run on A
      for (int unsigned k = 1; k <= 4; k++) send_rec(64'(k), k == 4);
      drain("drain_t1");

      // Two-record run on B, held under FUL_B while FUL_A toggles
      ful_b_set = 1'b1;
      ful_mode  = 2;
      @(negedge CLK);
      send_rec(64'd10, 1'b0);
      send_rec(64'd11, 1'b1);
      held = {SENT, SENT, 64'd11, 64'd10};
      for (int unsigned c = 0; c < 20; c++) begin
         @(negedge CLK);
         if (c == 0 || c == 19) begin
            chk("hold_enq_b", ENQ_B, 0);
            chk("hold_ready", IN_READY, 0);
            chk("hold_busy", BUSY, 1);
            chk("hold_word", DOT_B, held);
         end
      end
      ful_b_set = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      chk("hold_released", 256'(qb.size()), 256'(0)
`ifdef HMS_FEEDER_TERM_WORD_EN
          + 256'(1)
`endif
         );
      ful_mode  = 0;
      ful_a_set = 1'b0;
      drain("drain_t3");

      // Five-record run back on A: full word then padded word
      for (int unsigned k = 5; k <= 9; k++) send_rec(64'(k), k == 9);
      drain("drain_t2");

      // Reset mid-run discards the partial word
      send_rec(64'd20, 1'b0);
      send_rec(64'd21, 1'b0);
      @(negedge CLK);
      chk("midrun_busy", BUSY, 1);
      do_reset();
      send_rec(64'd3, 1'b1);
      drain("drain_t4");

      // Random runs under random backpressure
      ful_mode = 1;
      nrec     = 0;
      while (nrec < 10000) begin
         rlen = $urandom_range(1, 9);
         for (int unsigned k = 0; k < rlen; k++) begin
            if ($urandom_range(0, 3) == 0) @(negedge CLK);
            send_rec({$urandom(), 32'($urandom_range(0, 32'hFFFF_FFFE))}, k == rlen - 1);
            nrec++;
         end
      end
      ful_mode  = 0;
      ful_a_set = 1'b0;
      ful_b_set = 1'b0;
      drain("drain_rand");
      @(negedge CLK);
      chk("final_busy", BUSY, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hms_run_feeder.md
Name: hms_run_feeder

Overview:
- Upstream transmitter for the two-input merge logic.
- Accepts a stream of single records grouped into sorted runs, and packs each run into E-record words (E = 1<<E_LOG).
- Pads each run's final word with max-key sentinels and enqueues the words into merge input A or B, honouring the FUL_A/FUL_B backpressure.
- Runs alternate between ports: run 0 goes to A, run 1 to B, run 2 to A, and so on.

Parameters:
E_LOG, 2, log2 of records per word
DATW, 64, record width in bits
KEYW, 32, key width; the key occupies record bits [KEYW-1:0]

Ports:
CLK  in  1  clock
RST  in  1  reset; synchronous, active-high
IN_DATA  in  DATW  input record
IN_VALID  in  1  IN_DATA valid
IN_LAST  in  1  qualifies IN_DATA as the last record of the current run
IN_READY  out  1  feeder accepts a record this cycle
FUL_A  in  1  merge FIFO A full; no enqueue allowed while high
FUL_B  in  1  merge FIFO B full
ENQ_A  out  1  enqueue word to A
ENQ_B  out  1  enqueue word to B
DOT_A  out  DATW<<E_LOG  word for A
DOT_B  out  DATW<<E_LOG  word for B
RUN_DONE  out  1  one-cycle pulse when the last word of a run is enqueued (including the term word if enabled)
BUSY  out  1  partial word held, or word pending

Behaviour:
Definitions:
- Sentinel record: key bits all ones, bits [DATW-1:KEYW] zero.
- Input keys must be strictly less than all-ones. This is not checked.
- Lane i occupies word bits [DATW*(i+1)-1 : DATW*i]. Within a run, records fill lanes 0..E-1 in arrival order. Words are emitted in run order.

Reset (RST=1):
- state=FILL, idx=0, sel=A, word_valid=0, last_flag=0.
- All outputs low except IN_READY, which is 1 one cycle after reset deasserts.
- DOT_A/DOT_B content is don't-care.
- RST mid-run discards any partial or pending word. The next accepted record starts a new run on A.

State machine (state, idx[E_LOG-1:0], sel, last_flag):
- FILL:
  - IN_READY = 1.
  - On IN_VALID: write lane[idx]=IN_DATA.
  - If idx==E-1 or IN_LAST: fill lanes idx+1..E-1 with sentinels, set word_valid, last_flag=IN_LAST, idx=0, go to SEND.
  - Otherwise idx++.
- SEND:
  - IN_READY = 0.
  - ENQ_sel = !FUL_sel. ENQ of the other port = 0. DOT_A = DOT_B = word buffer.
  - On enqueue with last_flag=0: go to FILL.
  - On enqueue with last_flag=1: pulse RUN_DONE, toggle sel, go to FILL (see Optional Feature).
  - While FUL_sel=1: hold the word and wait indefinitely. The other port's FUL is ignored.

Latency and throughput:
- Record accepted at cycle t that completes a word: ENQ earliest at t+1.
- Full run: E accept cycles plus 1 SEND cycle per word.

ENQ rules:
- ENQ_A and ENQ_B are never high together.
- ENQ is never high while the corresponding FUL is high.

Boundary conditions:
- IN_LAST on lane E-1: no padding.
- IN_LAST on lane 0: lanes 1..E-1 are sentinels.
- A single-record run is legal.
- IN_VALID while IN_READY=0 is ignored; the source must hold its data.

BUSY = (idx!=0) | (state!=FILL).

Optional Feature:
Macro HMS_FEEDER_TERM_WORD_EN.
- Defined:
  - After enqueuing a word with last_flag=1, go to state TERM instead of FILL.
  - TERM: word buffer = E sentinels; ENQ_sel = !FUL_sel.
  - On enqueue in TERM: pulse RUN_DONE, toggle sel, go to FILL.
  - This flushes the merge network's feedback registers with a full sentinel word.
- Undefined: TERM state is absent; behaviour is as in Behaviour.

Decomposition:
- Shared package `hms_pkg`:
  - constants: `E = 1<<E_LOG`, word width `DATW<<E_LOG`, sentinel-record constant function of (DATW, KEYW);
  - state encoding FILL/SEND/TERM;
  - port-select encoding A=0, B=1.
- Sub-module `hms_word_packer`:
  - holds the lane registers, idx, and sentinel padding;
  - emits the word and a done flag.
- The top level keeps the FSM, sel, and ENQ/FUL logic.

Test Plan:
All tests use E_LOG=2, DATW=64, KEYW=32, sentinel record = 64'h0000_0000_FFFF_FFFF.
1. Run keys 1,2,3,4 (IN_LAST on 4), FUL=0 -> one ENQ_A, word lanes0..3 = 1,2,3,4; RUN_DONE pulse; next run goes to B.
2. Run keys 5,6,7,8,9 (IN_LAST on 9) -> ENQ_A {5,6,7,8}, then ENQ_A {9,S,S,S}; RUN_DONE once; IN_READY low in each SEND cycle.
3. Second run keys 10,11 with FUL_B high for 20 cycles -> ENQ_B stays 0, IN_READY=0, word held; ENQ_B {10,11,S,S} the cycle after FUL_B falls; FUL_A toggling has no effect.
4. RST asserted after 2 records of a run -> nothing enqueued; BUSY=0; next run's first word goes to A.
5. With HMS_FEEDER_TERM_WORD_EN, run keys 3 (IN_LAST) -> ENQ_A {3,S,S,S}, then ENQ_A {S,S,S,S}; RUN_DONE only on the second; next run goes to B.
6. Random runs with random FUL_A/FUL_B, 10k records -> scoreboard shows per-port word order preserved, exact padding, runs alternate A/B, and no ENQ while FUL is high.
